// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared state encoding and constants for the ALU arbiter.
// Contents: state_t (IDLE/ISSUE/WAIT/RESPOND, 2 bits), DEFAULT_DATA_W,
// FLAG_ALU_ERR (error flag bit) and ERR_FLAGS (flags value reported on abort).
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_W = 8;
    localparam int FLAG_ALU_ERR   = 7;
    localparam logic [7:0] ERR_FLAGS = 8'(1) << FLAG_ALU_ERR;

endpackage

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker.
// Ports:
//   req     in  N_REQ  request vector
//   ptr     in  IDX_W  highest-priority index for this pick
//   pick    out N_REQ  one-hot selected requester (0 when no request)
//   idx     out IDX_W  index of the selected requester
//   any_req out 1      at least one request present
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] idx,
    output logic             any_req
);

    logic [IDX_W-1:0] c;

    // Scan offsets from farthest to nearest so the requester closest to
    // ptr (cyclically) is the last assignment and therefore wins.
    always_comb begin
        idx = '0;
        c   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            c = IDX_W'((int'(ptr) + k) % N_REQ);
            if (req[c]) idx = c;
        end
        any_req = |req;
        pick    = any_req ? N_REQ'(1) << idx : '0;
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one ALU between N_REQ cores.
// Optional feature: define ALU_ARB_TIMEOUT_EN to abort a WAIT lasting TIMEOUT
// cycles, responding with result=0 and flags=ERR_FLAGS.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req[N_REQ]                      per-core request, held until rsp_valid
//   opcode_in/operand1_in/operand2_in  per-core packed operation (slice i = core i)
//   gnt[N_REQ]                      one-hot grant, ISSUE through WAIT
//   rsp_valid[N_REQ]                one-hot one-cycle response strobe
//   result, flags                   response data, held until next RESPOND
//   alu_opcode, alu_a, alu_b        registered operation to the shared ALU
//   alu_start                       one-cycle start pulse
//   alu_done, alu_result, alu_flags ALU completion and outputs
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] opcode_in,
    input  logic [N_REQ*DATA_W-1:0] operand1_in,
    input  logic [N_REQ*DATA_W-1:0] operand2_in,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       result,
    output logic [DATA_W-1:0]       flags,
    output logic [DATA_W-1:0]       alu_opcode,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic                    alu_start,
    input  logic                    alu_done,
    input  logic [DATA_W-1:0]       alu_result,
    input  logic [DATA_W-1:0]       alu_flags
);

    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("alu_arbiter: parameter out of range");
    end

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick;
    logic             any_req;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (req),
        .ptr     (rr_ptr),
        .pick    (pick),
        .idx     (pick_idx),
        .any_req (any_req)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            idx        <= '0;
            gnt        <= '0;
            rsp_valid  <= '0;
            result     <= '0;
            flags      <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_start  <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            alu_start <= 1'b0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        idx        <= pick_idx;
                        alu_opcode <= opcode_in[pick_idx*DATA_W +: DATA_W];
                        alu_a      <= operand1_in[pick_idx*DATA_W +: DATA_W];
                        alu_b      <= operand2_in[pick_idx*DATA_W +: DATA_W];
                        gnt        <= pick;
                        alu_start  <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                // alu_done here would be same-cycle as start; deliberately ignored.
                ISSUE: begin
`ifdef ALU_ARB_TIMEOUT_EN
                    cnt   <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (alu_done) begin
                        result    <= alu_result;
                        flags     <= alu_flags;
                        rsp_valid <= gnt;
                        gnt       <= '0;
                        state     <= RESPOND;
                    end
`ifdef ALU_ARB_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        result    <= '0;
                        flags     <= DATA_W'(ERR_FLAGS);
                        rsp_valid <= gnt;
                        gnt       <= '0;
                        state     <= RESPOND;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RESPOND: begin
                    rr_ptr <= (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with a behavioural ALU and response scoreboard.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] opcode_in = '0;
    logic [31:0] operand1_in = '0;
    logic [31:0] operand2_in = '0;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [7:0]  result, flags, alu_opcode, alu_a, alu_b;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic [7:0]  alu_result = '0;
    logic [7:0]  alu_flags = '0;

    int alu_delay = 1;
    bit never_done = 1'b0;
    int dcnt = 0;

    typedef struct {
        int         core;
        logic [7:0] res;
        logic [7:0] flg;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int vectors = 0;
    int miscompares = 0;

    alu_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .opcode_in   (opcode_in),
        .operand1_in (operand1_in),
        .operand2_in (operand2_in),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .result      (result),
        .flags       (flags),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_start   (alu_start),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] f_res(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        return op == 8'h01 ? 8'(a + b) : op == 8'h02 ? 8'(a - b) : a ^ b;
    endfunction

    function automatic logic [7:0] f_flg(input logic [7:0] r);
        return r == 8'h00 ? 8'h01 : 8'h00;
    endfunction

    // Behavioural ALU: done arrives alu_delay cycles after the start cycle.
    always @(posedge clk) begin
        alu_done <= 1'b0;
        if (alu_start && !never_done) begin
            if (alu_delay <= 1) begin
                alu_done   <= 1'b1;
                alu_result <= f_res(alu_opcode, alu_a, alu_b);
                alu_flags  <= f_flg(f_res(alu_opcode, alu_a, alu_b));
                dcnt       <= 0;
            end else begin
                dcnt <= alu_delay - 1;
            end
        end else if (dcnt == 1) begin
            alu_done   <= 1'b1;
            alu_result <= f_res(alu_opcode, alu_a, alu_b);
            alu_flags  <= f_flg(f_res(alu_opcode, alu_a, alu_b));
            dcnt       <= 0;
        end else if (dcnt > 1) begin
            dcnt <= dcnt - 1;
        end
    end

    // Scoreboard: every response strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid !== 4'b0000) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_rsp: rsp_valid=%b with nothing expected", rsp_valid);
            end else begin
                e = sb.pop_front();
                if (rsp_valid !== (4'b0001 << e.core) || result !== e.res || flags !== e.flg) begin
                    miscompares++;
                    $display("FAIL rsp_core%0d: rsp_valid=%b result=%h flags=%h, want rsp_valid=%b result=%h flags=%h",
                             e.core, rsp_valid, result, flags, 4'b0001 << e.core, e.res, e.flg);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic set_core(input int c, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        opcode_in[c*8 +: 8]   = op;
        operand1_in[c*8 +: 8] = a;
        operand2_in[c*8 +: 8] = b;
    endtask

    task automatic push(input int c, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = f_res(op, a, b);
        sb.push_back('{core: c, res: r, flg: f_flg(r)});
    endtask

    task automatic wait_rsp(input int c, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (rsp_valid[c]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({gnt, rsp_valid, alu_start} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: gnt=%b rsp_valid=%b alu_start=%b, want all 0", gnt, rsp_valid, alu_start);
        end
        vectors++;
        if ({result, flags, alu_opcode, alu_a, alu_b} !== 40'd0) begin
            miscompares++;
            $display("FAIL reset_data: result=%h flags=%h op=%h a=%h b=%h, want all 0", result, flags, alu_opcode, alu_a, alu_b);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        set_core(0, 8'h01, 8'd5, 8'd3);
        push(0, 8'h01, 8'd5, 8'd3);
        req = 4'b0001;
        @(negedge clk);
        vectors++;
        if (alu_start !== 1'b1 || gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_issue: alu_start=%b gnt=%b, want 1 0001", alu_start, gnt);
        end
        vectors++;
        if ({alu_opcode, alu_a, alu_b} !== {8'h01, 8'd5, 8'd3}) begin
            miscompares++;
            $display("FAIL single_operands: op=%h a=%h b=%h, want 01 05 03", alu_opcode, alu_a, alu_b);
        end
        @(negedge clk);
        vectors++;
        if (alu_start !== 1'b0 || rsp_valid !== 4'b0000 || gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_wait: alu_start=%b rsp_valid=%b gnt=%b, want 0 0000 0001", alu_start, rsp_valid, gnt);
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 4'b0001 || gnt !== 4'b0000 || result !== 8'd8 || flags !== 8'h00) begin
            miscompares++;
            $display("FAIL single_respond: rsp_valid=%b gnt=%b result=%h flags=%h, want 0001 0000 08 00", rsp_valid, gnt, result, flags);
        end
        req = 4'b0000;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 4'b0000 || result !== 8'd8) begin
            miscompares++;
            $display("FAIL single_hold: rsp_valid=%b result=%h, want 0000 08", rsp_valid, result);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        pulse_reset();
        for (int c = 0; c < 4; c++) begin
            set_core(c, 8'h01, 8'(10 * c + 1), 8'(c));
            push(c, 8'h01, 8'(10 * c + 1), 8'(c));
        end
        push(0, 8'h02, 8'd50, 8'd7);
        req = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            wait_rsp(c, 20, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL rr_core%0d: no rsp_valid within 20 cycles", c);
            end
            if (c == 0) set_core(0, 8'h02, 8'd50, 8'd7);
            else req[c] = 1'b0;
        end
        wait_rsp(0, 20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rr_rerequest: core 0 second rsp_valid missing within 20 cycles");
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        bit ok;
        set_core(1, 8'h03, 8'hAA, 8'h0F);
        set_core(2, 8'h02, 8'd20, 8'd20);
        push(1, 8'h03, 8'hAA, 8'h0F);
        push(2, 8'h02, 8'd20, 8'd20);
        push(1, 8'h01, 8'd100, 8'd27);
        req = 4'b0110;
        wait_rsp(1, 20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL fair_first: core 1 rsp_valid missing within 20 cycles");
        end
        set_core(1, 8'h01, 8'd100, 8'd27);
        repeat (2) @(negedge clk);
        vectors++;
        if (gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL fair_grant: gnt=%b after core 1 response, want 0100", gnt);
        end
        wait_rsp(2, 20, ok);
        req[2] = 1'b0;
        wait_rsp(1, 20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL fair_second: core 1 second rsp_valid missing within 20 cycles");
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_operand_isolation();
        bit ok;
        alu_delay = 3;
        set_core(0, 8'h01, 8'd5, 8'd3);
        push(0, 8'h01, 8'd5, 8'd3);
        req = 4'b0001;
        repeat (2) @(negedge clk);
        operand1_in[7:0] = 8'd9;
        @(negedge clk);
        vectors++;
        if (alu_a !== 8'd5) begin
            miscompares++;
            $display("FAIL iso_alu_a: alu_a=%0d after operand change, want 5", alu_a);
        end
        wait_rsp(0, 20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL iso_rsp: no rsp_valid within 20 cycles");
        end
        req = 4'b0000;
        alu_delay = 1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        alu_delay = 4;
        set_core(3, 8'h02, 8'd9, 8'd4);
        req = 4'b1000;
        @(negedge clk);
        vectors++;
        if (alu_start !== 1'b1 || gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL rmid_issue: alu_start=%b gnt=%b, want 1 1000", alu_start, gnt);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (gnt !== 4'b0000 || rsp_valid !== 4'b0000 || alu_start !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_abort: gnt=%b rsp_valid=%b alu_start=%b, want 0000 0000 0", gnt, rsp_valid, alu_start);
        end
        reset = 1'b0;
        req = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 4'b0000 || result !== 8'h00) begin
                miscompares++;
                $display("FAIL rmid_late_done: rsp_valid=%b result=%h at cycle %0d, want 0000 00", rsp_valid, result, i);
            end
        end
        alu_delay = 1;
        set_core(2, 8'h01, 8'd1, 8'd2);
        push(2, 8'h01, 8'd1, 8'd2);
        req = 4'b0100;
        @(negedge clk);
        vectors++;
        if (alu_start !== 1'b1 || gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL rmid_restart: alu_start=%b gnt=%b, want 1 0100", alu_start, gnt);
        end
        wait_rsp(2, 20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rmid_restart_rsp: no rsp_valid within 20 cycles");
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

`ifdef ALU_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        never_done = 1'b1;
        set_core(1, 8'h01, 8'd3, 8'd4);
        sb.push_back('{core: 1, res: 8'h00, flg: 8'h80});
        req = 4'b0010;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid[1]) break;
        end
        vectors++;
        if (n !== 18) begin
            miscompares++;
            $display("FAIL timeout_latency: rsp_valid after %0d cycles, want 18", n);
        end
        req = 4'b0000;
        never_done = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_operand_isolation();
        test_reset_mid();
`ifdef ALU_ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (4) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
